load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_store_unit: byte/half/word load-store bridge from pipeline to a      |
// | ready/valid word bus. Optional MISALIGN_TRAP_EN traps misaligned accesses.|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        stall,
  output logic        misalign,
  output logic        bus_timeout,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int              CW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   c_CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      c_F3_B     = 3'd0;
  localparam logic [2:0]      c_F3_H     = 3'd1;
  localparam logic [2:0]      c_F3_W     = 3'd2;
  localparam logic [2:0]      c_F3_BU    = 3'd4;
  localparam logic [2:0]      c_F3_HU    = 3'd5;

  logic [1:0]    r_state;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [2:0]    r_func3;
  logic          r_we;
  logic          r_timeout;
  logic [CW-1:0] r_cnt;

  logic          w_req;
  logic          w_done;
  logic          w_trap;
  logic          w_f3_ok;
  logic [1:0]    w_off;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_shift;
  logic [31:0]   w_load;

  assign w_f3_ok = (func3 == c_F3_B) || (func3 == c_F3_H) || (func3 == c_F3_W) ||
                   (func3 == c_F3_BU) || (func3 == c_F3_HU);

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_trap = ((func3[1:0] == 2'b01) && addr[0]) ||
                  ((func3 == c_F3_W) && (addr[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  // Halves and words are forced onto their natural boundary; in trap mode
  // misaligned requests never reach REQ so this is a no-op there.
  always_comb begin
    w_off = r_addr[1:0];
    if (r_func3[1:0] == 2'b01)
      w_off[0] = 1'b0;
    else if (r_func3[1:0] == 2'b10)
      w_off = 2'b00;
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (r_func3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  assign w_shift = bus_rdata >> {w_off, 3'b000};

  always_comb begin
    w_load = w_shift;
    case (r_func3)
      c_F3_B:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      c_F3_H:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      c_F3_BU: w_load = {24'd0, w_shift[7:0]};
      c_F3_HU: w_load = {16'd0, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_func3   <= '0;
      r_we      <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
`ifdef MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (MemRead || MemWrite) begin
            r_addr    <= addr;
            r_func3   <= func3;
            r_wdata   <= w_data;
            r_we      <= MemWrite;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_misalign <= w_trap;
`endif
            r_state   <= (!w_f3_ok || w_trap) ? DONE : REQ;
          end
        end
        REQ: begin
          // bus_ready on the limit cycle still completes normally
          if (bus_ready) begin
            r_rdata <= r_we ? 32'd0 : w_load;
            r_state <= DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == c_CNT_LAST)) begin
            r_timeout <= 1'b1;
            r_rdata   <= '0;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_rdata   <= '0;
          r_timeout <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          r_misalign <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_req  = (r_state == REQ);
  assign w_done = (r_state == DONE);

  // rst gates the combinational IDLE stall so every output reads 0 in reset
  assign stall       = (r_state == IDLE) ? (!rst && (MemRead || MemWrite)) : w_req;
  assign bus_valid   = w_req;
  assign bus_we      = w_req & r_we;
  assign bus_addr    = w_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign bus_be      = w_req ? w_be : 4'd0;
  assign bus_wdata   = w_req ? w_wdata : 32'd0;
  assign r_data      = w_done ? r_rdata : 32'd0;
  assign bus_timeout = w_done & r_timeout;
`ifdef MISALIGN_TRAP_EN
  assign misalign    = w_done & r_misalign;
`else
  assign misalign    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// Directed-vector bench for load_store_unit: table of single accesses plus
// hand sequences for bus stalls, timeout and asynchronous reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [2:0]  func3;
  logic [31:0] addr, w_data, bus_rdata;
  logic        bus_ready;
  logic [31:0] r_data, bus_addr, bus_wdata;
  logic        stall, misalign, bus_timeout, bus_valid, bus_we;
  logic [3:0]  bus_be;

  logic        mr2, ready2;
  logic [31:0] r_data2, bus_addr2, bus_wdata2;
  logic        stall2, misalign2, timeout2, valid2, we2;
  logic [3:0]  be2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .func3(func3),
    .addr(addr), .w_data(w_data), .r_data(r_data), .stall(stall), .misalign(misalign),
    .bus_timeout(bus_timeout), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .MemRead(mr2), .MemWrite(1'b0), .func3(func3),
    .addr(addr), .w_data(w_data), .r_data(r_data2), .stall(stall2), .misalign(misalign2),
    .bus_timeout(timeout2), .bus_valid(valid2), .bus_we(we2),
    .bus_addr(bus_addr2), .bus_wdata(bus_wdata2), .bus_be(be2),
    .bus_ready(ready2), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdat;
    logic        bus;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_rdata;
    logic        e_mis;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rdat, logic bus,
                              logic [31:0] e_addr, logic [3:0] e_be,
                              logic [31:0] e_wdata, logic [31:0] e_rdata, logic e_mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd; v.rdat = rdat; v.bus = bus;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    vt[0]  = mk(0, 1, 3'd0, 32'h103, 32'hAB,       32'h0,        1, 32'h100, 4'b1000, 32'hABABABAB, 32'h0,        0);
    vt[1]  = mk(1, 0, 3'd0, 32'h102, 32'h0,        32'h00800000, 1, 32'h100, 4'b0100, 32'h0,        32'hFFFFFF80, 0);
    vt[2]  = mk(1, 0, 3'd4, 32'h102, 32'h0,        32'h00800000, 1, 32'h100, 4'b0100, 32'h0,        32'h00000080, 0);
    vt[3]  = mk(0, 1, 3'd1, 32'h2,   32'h1234ABCD, 32'h0,        1, 32'h0,   4'b1100, 32'hABCDABCD, 32'h0,        0);
    vt[4]  = mk(0, 1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0,        1, 32'h10,  4'b1111, 32'hDEADBEEF, 32'h0,        0);
    vt[5]  = mk(1, 0, 3'd5, 32'h6,   32'h0,        32'h80010000, 1, 32'h4,   4'b1100, 32'h0,        32'h00008001, 0);
`ifdef MISALIGN_TRAP_EN
    vt[6]  = mk(1, 0, 3'd2, 32'h6,   32'h0,        32'h12345678, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1);
    vt[9]  = mk(1, 0, 3'd1, 32'h3,   32'h0,        32'hFFFE0000, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1);
`else
    vt[6]  = mk(1, 0, 3'd2, 32'h6,   32'h0,        32'h12345678, 1, 32'h4,   4'b1111, 32'h0,        32'h12345678, 0);
    vt[9]  = mk(1, 0, 3'd1, 32'h3,   32'h0,        32'hFFFE0000, 1, 32'h0,   4'b1100, 32'h0,        32'hFFFFFFFE, 0);
`endif
    vt[7]  = mk(1, 0, 3'd3, 32'h40,  32'h0,        32'hFFFFFFFF, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0);
    vt[8]  = mk(1, 0, 3'd0, 32'h1,   32'h0,        32'h00007F00, 1, 32'h0,   4'b0010, 32'h0,        32'h0000007F, 0);
    vt[10] = mk(1, 1, 3'd2, 32'h20,  32'h11223344, 32'h55555555, 1, 32'h20,  4'b1111, 32'h11223344, 32'h0,        0);

    // reset state, with a pipeline request pending that must be ignored
    rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; func3 = 3'd2; addr = 32'h104;
    w_data = 32'hFFFFFFFF; bus_rdata = 32'h0; bus_ready = 1'b0; mr2 = 1'b0; ready2 = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_outs", {bus_addr | bus_wdata | r_data}, 32'd0);
    chk("rst_misc", {26'd0, bus_be, bus_we, misalign | bus_timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0; MemRead = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      func3 = vt[i].f3; addr = vt[i].a; w_data = vt[i].wd; bus_rdata = vt[i].rdat;
      MemRead = vt[i].rd; MemWrite = vt[i].wr; bus_ready = 1'b1;
      #1 chk($sformatf("v%0d_idle_stall", i), {31'd0, stall}, 32'd1);
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      if (vt[i].bus) begin
        chk($sformatf("v%0d_valid", i), {31'd0, bus_valid}, 32'd1);
        chk($sformatf("v%0d_we", i), {31'd0, bus_we}, {31'd0, vt[i].wr});
        chk($sformatf("v%0d_addr", i), bus_addr, vt[i].e_addr);
        chk($sformatf("v%0d_be", i), {28'd0, bus_be}, {28'd0, vt[i].e_be});
        if (vt[i].wr) chk($sformatf("v%0d_wdata", i), bus_wdata, vt[i].e_wdata);
        chk($sformatf("v%0d_req_stall", i), {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1;
      end
      chk($sformatf("v%0d_done_valid", i), {31'd0, bus_valid}, 32'd0);
      chk($sformatf("v%0d_done_stall", i), {31'd0, stall}, 32'd0);
      chk($sformatf("v%0d_rdata", i), r_data, vt[i].e_rdata);
      chk($sformatf("v%0d_misalign", i), {31'd0, misalign}, {31'd0, vt[i].e_mis});
    end

    // half load with bus_ready held low for five REQ cycles
    @(negedge clk);
    func3 = 3'd1; addr = 32'h2; w_data = 32'h0; bus_rdata = 32'h80010000;
    MemRead = 1'b1; bus_ready = 1'b0;
    @(negedge clk);
    MemRead = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("wait%0d_valid", k), {31'd0, bus_valid}, 32'd1);
      chk($sformatf("wait%0d_addr", k), bus_addr, 32'h0);
      chk($sformatf("wait%0d_be_we", k), {27'd0, bus_be, bus_we}, {27'd0, 4'b1100, 1'b0});
      chk($sformatf("wait%0d_stall", k), {31'd0, stall}, 32'd1);
      @(negedge clk);
    end
    bus_ready = 1'b1;
    #1 chk("wait_last_valid", {31'd0, bus_valid}, 32'd1);
    @(negedge clk);
    #1;
    chk("wait_rdata", r_data, 32'hFFFF8001);
    chk("wait_done_valid", {31'd0, bus_valid}, 32'd0);

    // timeout with TIMEOUT_CYCLES=4
    @(negedge clk);
    func3 = 3'd2; addr = 32'h40; bus_rdata = 32'hCAFEF00D; mr2 = 1'b1; ready2 = 1'b0;
    @(negedge clk);
    mr2 = 1'b0;
    begin
      int vcnt;
      bit fin;
      vcnt = 0; fin = 1'b0;
      for (int k = 0; k < 20 && !fin; k++) begin
        #1;
        if (valid2) vcnt++;
        else fin = 1'b1;
        if (!fin) @(negedge clk);
      end
      chk("to_ended", {31'd0, fin}, 32'd1);
      chk("to_valid_cycles", vcnt, 32'd4);
    end
    chk("to_pulse", {31'd0, timeout2}, 32'd1);
    chk("to_rdata", r_data2, 32'd0);
    chk("to_stall", {31'd0, stall2}, 32'd0);
    @(negedge clk);
    #1 chk("to_pulse_clear", {31'd0, timeout2}, 32'd0);

    // bus_ready on the fourth REQ cycle wins over the timeout
    @(negedge clk);
    mr2 = 1'b1;
    @(negedge clk);
    mr2 = 1'b0;
    repeat (3) @(negedge clk);
    ready2 = 1'b1;
    #1 chk("to4_valid", {31'd0, valid2}, 32'd1);
    @(negedge clk);
    ready2 = 1'b0;
    #1;
    chk("to4_no_pulse", {31'd0, timeout2}, 32'd0);
    chk("to4_rdata", r_data2, 32'hCAFEF00D);

    // asynchronous reset in the middle of REQ
    @(negedge clk);
    func3 = 3'd2; addr = 32'h100; MemRead = 1'b1; bus_ready = 1'b0;
    @(negedge clk);
    #1 chk("mid_valid_before", {31'd0, bus_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_valid_after", {31'd0, bus_valid}, 32'd0);
    chk("mid_stall", {31'd0, stall}, 32'd0);
    chk("mid_bus", bus_addr | bus_wdata, 32'd0);
    chk("mid_be", {28'd0, bus_be}, 32'd0);
    @(negedge clk);
    rst = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
